pc_fetch_seq: RTL and testbench

//  Program-counter register and fetch sequencer; the consumer side of the 16-bit PC adder path.

---
 rtl/pc_fetch_seq.sv | 134 +++++++++++++
 tb/tb_pc_fetch_seq.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_seq.sv
// Program-counter register and fetch sequencer driving a req/ack instruction-memory port.
// Optional misaligned-target trap is enabled by defining PC_MISALIGN_TRAP_EN.
module pc_fetch_seq #(
  parameter int              PC_W     = 16,
  parameter logic [PC_W-1:0] RESET_PC = 16'h0000,
  parameter int              INC      = 2,
  parameter logic [PC_W-1:0] TRAP_VEC = 16'h0010
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            br_take_i,
  input  logic [PC_W-1:0] br_offset_i,
  input  logic            jmp_take_i,
  input  logic [PC_W-1:0] jmp_addr_i,
  output logic            fetch_req_o,
  output logic [PC_W-1:0] fetch_addr_o,
  input  logic            fetch_ack_i,
  output logic [PC_W-1:0] pc_o,
  output logic [PC_W-1:0] pc_seq_o,
  output logic            trap_o
);

  typedef enum logic [1:0] {S_BOOT, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t          state_q;
  logic [PC_W-1:0] pc_q;
  logic            fetch_req_q;
  logic            trap_q;
  logic            pend_q;
  logic [PC_W-1:0] pend_tgt_q;

  logic            redir;
  logic [PC_W-1:0] redir_tgt;
  logic [PC_W-1:0] pc_seq;
  logic [PC_W-1:0] sel_pc;
  logic            misalign;
  logic [PC_W-1:0] next_pc_d;

  assign pc_seq = pc_q + PC_W'(INC);

  // Target selection shared by the ack path and the HOLD exit path; only the
  // fallback differs (advance after an accepted fetch, stay put when resuming).
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    misalign  = 1'b0;
    redir     = jmp_take_i | br_take_i;
    redir_tgt = jmp_take_i ? jmp_addr_i : pc_q + br_offset_i;
    if (redir)                 sel_pc = redir_tgt;
    else if (pend_q)           sel_pc = pend_tgt_q;
    else if (state_q == S_HOLD) sel_pc = pc_q;
    else                       sel_pc = pc_seq;
`ifdef PC_MISALIGN_TRAP_EN
    misalign = (sel_pc % PC_W'(INC)) != '0;
`endif
    next_pc_d = misalign ? TRAP_VEC : sel_pc;
  end

  // NOTE: state is updated with non-blocking assignments only, so every branch
  // below sees the pre-edge values of all registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_BOOT;
      pc_q        <= RESET_PC;
      fetch_req_q <= 1'b0;
      trap_q      <= 1'b0;
      pend_q      <= 1'b0;
      pend_tgt_q  <= '0;
    end else begin
      trap_q <= 1'b0;
      case (state_q)
        S_BOOT: begin
          state_q     <= S_REQ;
          fetch_req_q <= 1'b1;
          if (redir) begin
            pend_q     <= 1'b1;
            pend_tgt_q <= redir_tgt;
          end
        end
        S_REQ, S_WAIT: begin
          if (fetch_ack_i) begin
            pc_q   <= next_pc_d;
            trap_q <= misalign;
            pend_q <= 1'b0;
            if (stall_i) begin
              state_q     <= S_HOLD;
              fetch_req_q <= 1'b0;
            end else begin
              state_q     <= S_REQ;
              fetch_req_q <= 1'b1;
            end
          end else begin
            // The request in flight keeps its address; redirects wait for its ack.
            if (redir) begin
              pend_q     <= 1'b1;
              pend_tgt_q <= redir_tgt;
            end
            if (state_q == S_REQ && stall_i) begin
              state_q     <= S_HOLD;
              fetch_req_q <= 1'b0;
            end else if (state_q == S_REQ) begin
              state_q <= S_WAIT;
            end
          end
        end
        S_HOLD: begin
          if (stall_i) begin
            if (redir) begin
              pend_q     <= 1'b1;
              pend_tgt_q <= redir_tgt;
            end
          end else begin
            pc_q        <= next_pc_d;
            trap_q      <= misalign;
            pend_q      <= 1'b0;
            state_q     <= S_REQ;
            fetch_req_q <= 1'b1;
          end
        end
        default: begin
          state_q     <= S_BOOT;
          fetch_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign fetch_req_o  = fetch_req_q;
  assign fetch_addr_o = pc_q;
  assign pc_o         = pc_q;
  assign pc_seq_o     = pc_seq;
  assign trap_o       = trap_q;

endmodule

// File: tb/tb_pc_fetch_seq.sv
// Directed bench for pc_fetch_seq: expected fetch addresses are queued as stimulus
// is driven and popped on each req/ack handshake; state is checked between steps.
module tb_pc_fetch_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        br_take;
  logic [15:0] br_offset;
  logic        jmp_take;
  logic [15:0] jmp_addr;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        fetch_ack;
  logic [15:0] pc;
  logic [15:0] pc_seq;
  logic        trap;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [15:0] exp_q[$];
  logic [15:0] trap_pc;
  logic        trap_exp;

  pc_fetch_seq dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .stall_i      (stall),
    .br_take_i    (br_take),
    .br_offset_i  (br_offset),
    .jmp_take_i   (jmp_take),
    .jmp_addr_i   (jmp_addr),
    .fetch_req_o  (fetch_req),
    .fetch_addr_o (fetch_addr),
    .fetch_ack_i  (fetch_ack),
    .pc_o         (pc),
    .pc_seq_o     (pc_seq),
    .trap_o       (trap)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock step: drive inputs, queue the expected address if a handshake is
  // intended, score any handshake the DUT shows, then advance past the edge.
  task automatic cyc(input logic a, input logic hs, input logic [15:0] ea,
                     input logic st, input logic b, input logic [15:0] off,
                     input logic j, input logic [15:0] ja);
    fetch_ack = a; stall = st; br_take = b; br_offset = off;
    jmp_take = j; jmp_addr = ja;
    if (hs) exp_q.push_back(ea);
    #1;
    if (fetch_req && fetch_ack) begin
      if (exp_q.size() == 0) chk("sb_unexpected_hs", exp_q.size(), 1);
      else                   chk("sb_fetch_addr", fetch_addr, exp_q.pop_front());
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
`ifdef PC_MISALIGN_TRAP_EN
    trap_pc  = 16'h0010;
    trap_exp = 1'b1;
`else
    trap_pc  = 16'h0101;
    trap_exp = 1'b0;
`endif
    rst = 1'b1; stall = 1'b0; br_take = 1'b0; br_offset = '0;
    jmp_take = 1'b0; jmp_addr = '0; fetch_ack = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_fetch_req", fetch_req, 0);
    chk("rst_pc", pc, 16'h0000);
    chk("rst_trap", trap, 0);
    chk("rst_pc_seq", pc_seq, 16'h0002);

    // Sequential fetch with ack held high; the BOOT cycle ignores the ack.
    rst = 1'b0;
    cyc(1, 0, 16'h0000, 0, 0, 16'h0, 0, 16'h0);
    chk("boot_to_req", fetch_req, 1);
    chk("first_addr", fetch_addr, 16'h0000);
    cyc(1, 1, 16'h0000, 0, 0, 16'h0, 0, 16'h0);
    cyc(1, 1, 16'h0002, 0, 0, 16'h0, 0, 16'h0);
    chk("seq_pc", pc, 16'h0004);

    // Branch backward and forward from pc 0004.
    cyc(1, 1, 16'h0004, 0, 1, 16'hFFFC, 0, 16'h0);
    chk("br_back", pc, 16'h0000);
    cyc(1, 1, 16'h0000, 0, 0, 16'h0, 0, 16'h0);
    cyc(1, 1, 16'h0002, 0, 0, 16'h0, 0, 16'h0);
    cyc(1, 1, 16'h0004, 0, 1, 16'h0010, 0, 16'h0);
    chk("br_fwd", pc, 16'h0014);
    cyc(1, 1, 16'h0014, 0, 0, 16'h0, 1, 16'h0006);

    // Ack withheld; jump pulsed while waiting must not disturb the request.
    cyc(0, 0, 16'h0, 0, 0, 16'h0, 1, 16'h0100);
    chk("wait_req1", fetch_req, 1);
    chk("wait_addr1", fetch_addr, 16'h0006);
    cyc(0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0);
    chk("wait_addr2", fetch_addr, 16'h0006);
    cyc(0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0);
    chk("wait_req3", fetch_req, 1);
    chk("wait_addr3", fetch_addr, 16'h0006);
    cyc(1, 1, 16'h0006, 0, 0, 16'h0, 0, 16'h0);
    chk("pending_jmp", pc, 16'h0100);

    // Stall in REQ without ack drops the request; acks in HOLD are ignored.
    cyc(0, 0, 16'h0, 1, 0, 16'h0, 0, 16'h0);
    chk("hold_req", fetch_req, 0);
    chk("hold_pc", pc, 16'h0100);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 16'h0, 1, 0, 16'h0, 0, 16'h0);
      chk("hold_req_n", fetch_req, 0);
      chk("hold_pc_n", pc, 16'h0100);
    end
    cyc(0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0);
    chk("rereq", fetch_req, 1);
    chk("rereq_addr", fetch_addr, 16'h0100);

    // Wrap at the top of the address space, then jump beating branch.
    cyc(1, 1, 16'h0100, 0, 0, 16'h0, 1, 16'hFFFE);
    chk("top_pc", pc, 16'hFFFE);
    chk("top_pc_seq", pc_seq, 16'h0000);
    cyc(1, 1, 16'hFFFE, 0, 0, 16'h0, 0, 16'h0);
    chk("wrap_pc", pc, 16'h0000);
    cyc(1, 1, 16'h0000, 0, 1, 16'h0020, 1, 16'h0040);
    chk("jmp_over_br", pc, 16'h0040);

    // Redirect during stall applied on HOLD exit, before the re-request.
    cyc(0, 0, 16'h0, 1, 0, 16'h0, 1, 16'h0080);
    chk("stall_redir_hold", pc, 16'h0040);
    cyc(0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0);
    chk("stall_redir_pc", pc, 16'h0080);
    chk("stall_redir_req", fetch_req, 1);

    // Misaligned jump target.
    cyc(1, 1, 16'h0080, 0, 0, 16'h0, 1, 16'h0101);
    chk("misalign_pc", pc, trap_pc);
    chk("misalign_trap", trap, trap_exp);
    cyc(1, 1, trap_pc, 0, 0, 16'h0, 0, 16'h0);
    chk("trap_pulse_end", trap, 0);

    // Reset in WAIT abandons the request and the pending redirect.
    cyc(0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0);
    cyc(0, 0, 16'h0, 0, 0, 16'h0, 1, 16'h0200);
    chk("pre_rst_req", fetch_req, 1);
    rst = 1'b1;
    cyc(0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0);
    chk("midrst_req", fetch_req, 0);
    chk("midrst_pc", pc, 16'h0000);
    rst = 1'b0;
    cyc(0, 0, 16'h0, 0, 0, 16'h0, 0, 16'h0);
    cyc(1, 1, 16'h0000, 0, 0, 16'h0, 0, 16'h0);
    chk("pending_lost", pc, 16'h0002);

    chk("sb_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
